// File: rtl/uart_rx_8n1_pkg.sv
// Shared UART definitions: FSM state encoding, frame width and counter sizing.
// Shared by the RX and TX paths.
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_t;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_rx_8n1_if.sv
// Byte-stream handshake between the UART receiver (master) and its consumer (slave).
interface uart_rx_8n1_if;
  import uart_pkg::*;

  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 frame_err;
  logic                 overrun;
  logic                 rx_busy;

  modport master (
    output rx_data, rx_valid, frame_err, overrun, rx_busy,
    input  rx_ready
  );

  modport slave (
    input  rx_data, rx_valid, frame_err, overrun, rx_busy,
    output rx_ready
  );
endinterface

// File: rtl/uart_rx_8n1_sync_ff.sv
// Metastability synchroniser chain; flops preset to 1 so an idle-high line
// never looks like a start bit coming out of reset.
module sync_ff #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic [SYNC_STAGES-1:0] chain;

  always_ff @(posedge clk) begin
    if (!rst_n) chain <= '1;
    else        chain <= {chain[SYNC_STAGES-2:0], d};
  end

  assign q = chain[SYNC_STAGES-1];
endmodule

// File: rtl/uart_rx_8n1.sv
// 8N1 UART receiver with a one-byte holding register on a valid/ready handshake,
// framing-error and overrun pulses.
module uart_rx_8n1 #(
  parameter int CLKS_PER_BIT = 434,
  parameter int SYNC_STAGES  = 2
) (
  input  logic          CLOCK_50,
  input  logic          reset_n,
  input  logic          UART_RXD,
  uart_rx_8n1_if.master rx
);
  import uart_pkg::*;

  localparam int CNT_W = cnt_width(CLKS_PER_BIT);
  localparam int IDX_W = cnt_width(DATA_BITS);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

  logic                 rxs;
  rx_state_t            state;
  logic [CNT_W-1:0]     cnt;
  logic [IDX_W-1:0]     bit_idx;
  logic [DATA_BITS-1:0] shift;

  sync_ff #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk   (CLOCK_50),
    .rst_n (reset_n),
    .d     (UART_RXD),
    .q     (rxs)
  );

  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      state        <= IDLE;
      cnt          <= '0;
      bit_idx      <= '0;
      shift        <= '0;
      rx.rx_data   <= '0;
      rx.rx_valid  <= 1'b0;
      rx.frame_err <= 1'b0;
      rx.overrun   <= 1'b0;
      rx.rx_busy   <= 1'b0;
    end else begin
      rx.frame_err <= 1'b0;
      rx.overrun   <= 1'b0;
      // A byte loaded below in the same cycle overrides this clear.
      if (rx.rx_valid && rx.rx_ready) rx.rx_valid <= 1'b0;

      case (state)
        IDLE: begin
          cnt <= '0;
          if (!rxs) begin
            state      <= START;
            rx.rx_busy <= 1'b1;
          end
        end

        START: begin
          if (cnt == HALF_LAST) begin
            cnt <= '0;
            if (rxs) begin
              state      <= IDLE;
              rx.rx_busy <= 1'b0;
            end else begin
              state   <= DATA;
              bit_idx <= '0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        DATA: begin
          if (cnt == FULL_LAST) begin
            cnt   <= '0;
            shift <= {rxs, shift[DATA_BITS-1:1]};
            if (bit_idx == IDX_LAST) state <= STOP;
            else                     bit_idx <= bit_idx + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        STOP: begin
          if (cnt == FULL_LAST) begin
            cnt <= '0;
            if (rxs) begin
              if (!rx.rx_valid || rx.rx_ready) begin
                rx.rx_data  <= shift;
                rx.rx_valid <= 1'b1;
              end else begin
                rx.overrun <= 1'b1;
              end
              state      <= IDLE;
              rx.rx_busy <= 1'b0;
            end else begin
              rx.frame_err <= 1'b1;
              state        <= BREAK;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        BREAK: begin
          cnt <= '0;
          if (rxs) begin
            state      <= IDLE;
            rx.rx_busy <= 1'b0;
          end
        end

        default: begin
          state      <= IDLE;
          cnt        <= '0;
          rx.rx_busy <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: doc/uart_rx_8n1.md
Name: uart_rx_8n1

Overview:
- UART receiver for the board's UART_RXD pin; counterpart of the UART_TXD transmit path.
- Deserialises 8N1 frames (1 start bit, 8 data bits LSB first, 1 stop bit, no parity) into bytes.
- Presents each byte on a valid/ready handshake with a one-byte holding register.
- Feeds top-level logic (LEDR/HEX display, later the processor's memory-mapped I/O); reports framing and overrun errors.

Parameters:
- CLKS_PER_BIT, 434, CLOCK_50 cycles per bit (50 MHz / 115200). Must be an even integer, 4 or more.
- SYNC_STAGES, 2, number of metastability flip-flops on UART_RXD. Must be 2 or more.

Ports:
- CLOCK_50  in  1  system clock, rising edge.
- reset_n  in  1  synchronous reset, active-low.
- UART_RXD  in  1  asynchronous serial line, idle high.
- rx_data  out  8  received byte, stable while rx_valid=1.
- rx_valid  out  1  holding register full.
- rx_ready  in  1  consumer accepts the byte; transfer happens when rx_valid && rx_ready.
- frame_err  out  1  one-cycle pulse: stop bit sampled low.
- overrun  out  1  one-cycle pulse: a completed byte was dropped because the holding register was full.
- rx_busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (reset_n=0 at a clock edge):
  - rx_data=8'h00, rx_valid=0, frame_err=0, overrun=0, rx_busy=0.
  - State=IDLE, counters=0, synchroniser flops preset to 1.
- Synchroniser: UART_RXD passes through SYNC_STAGES flip-flops. All logic below uses the synchronised line rxs.
- FSM states: IDLE, START, DATA, STOP, BREAK.
- IDLE: rxs=0 -> START, with bit counter cnt cleared to 0.
- START: cnt counts up. When cnt==CLKS_PER_BIT/2-1, sample rxs:
  - rxs=1 -> IDLE (glitch rejected, no output).
  - rxs=0 -> DATA, cnt=0, bit index=0.
- DATA: sample rxs when cnt==CLKS_PER_BIT-1, i.e. the middle of each bit.
  - Shift the sample into a shift register, LSB first.
  - After bit index 7 -> STOP.
- STOP: sample at mid-bit (same rule as DATA).
  - rxs=1: valid frame.
    - rx_valid=0, or rx_ready=1 in the same cycle: load rx_data and set rx_valid=1 on the next edge, then IDLE.
    - Otherwise: pulse overrun; keep the old rx_data and rx_valid=1; go to IDLE.
  - rxs=0: pulse frame_err, discard the byte, rx_valid unchanged, go to BREAK.
- BREAK: wait for rxs=1, then IDLE. A held-low line produces exactly one frame_err.
- Handshake:
  - rx_valid && rx_ready at an edge clears rx_valid, unless a new byte loads in the same cycle; then rx_valid stays 1 and rx_data takes the new byte.
  - rx_data must not change while rx_valid=1 and no transfer occurs.
- Latency: rx_valid rises SYNC_STAGES + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1 cycles after the first edge that samples UART_RXD low. The bench allows ±1 cycle.
- Back-to-back frames: a start bit immediately after the stop mid-sample is detected, because the FSM is back in IDLE before the next falling edge.
- Reset mid-frame: the frame is abandoned and all outputs return to their reset values on the next edge. A partial frame never produces rx_valid.
- Counter width: $clog2(CLKS_PER_BIT). No wrap-around; the counter is reset on every state transition.

Decomposition:
- Package uart_pkg holds:
  - enum rx_state_t {IDLE, START, DATA, STOP, BREAK}
  - localparam DATA_BITS=8
  - function clog2-based counter width
  - the same package is shared with the UART TX block.
- Sub-module sync_ff (parameter SYNC_STAGES): reset-preset-to-1 synchroniser chain, reusable for SW/KEY inputs.

Test Plan (CLKS_PER_BIT=8, SYNC_STAGES=2):
- Single byte: drive 8'hA5 as a correct 8N1 frame with rx_ready=0.
  -> rx_valid=1 and rx_data=8'hA5 at latency 2+4+72+1=79 (±1); frame_err=0, overrun=0.
- Back-to-back: send 8'h0F, then 8'hF0 with no idle gap; rx_ready=1 throughout.
  -> two one-cycle rx_valid pulses with rx_data 8'h0F then 8'hF0.
- Overrun: send 8'h11 with rx_ready=0, then send 8'h22.
  -> overrun pulses once at the second stop sample; rx_data stays 8'h11, rx_valid stays 1.
- Framing error: send 8'h3C with the stop bit low, keep the line low for 40 cycles, then return high.
  -> exactly one frame_err pulse, rx_valid stays 0. Then send 8'h5A -> rx_data=8'h5A.
- Glitch: pulse UART_RXD low for 2 cycles.
  -> rx_busy rises, returns to IDLE after the start sample, no rx_valid, no frame_err.
- Reset mid-frame: assert reset_n=0 during data bit 3 of 8'hFF for 1 cycle.
  -> next edge: all outputs 0, rx_busy=0, and no rx_valid for the abandoned frame.
